// File: rtl/booth_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_controller_if
//  Description : Control/status bundle between the Booth multiplier
//                controller and its datapath.
//                master : controller side (drives controls, busy, done)
//                slave  : datapath/host side (drives start, q0, qm1, eqz)
//  Signals     : start, q0, qm1, eqz                     datapath -> ctrl
//                LdA, LdQ, LdM, clrA, clrQ, clrff,
//                sftA, sftQ, addsub, decr, ldcnt         ctrl -> datapath
//                busy, done                              ctrl status
//                cycle_cnt[5:0]                          only when
//                                                        BOOTH_CYCLE_CNT_EN
//  Options     : BOOTH_CYCLE_CNT_EN adds the cycle_cnt status field.
//  Revision    : 1.0  initial release
// ============================================================================
interface booth_controller_if;
   logic start;
   logic q0;
   logic qm1;
   logic eqz;

   logic LdA;
   logic LdQ;
   logic LdM;
   logic clrA;
   logic clrQ;
   logic clrff;
   logic sftA;
   logic sftQ;
   logic addsub;
   logic decr;
   logic ldcnt;

   logic busy;
   logic done;
`ifdef BOOTH_CYCLE_CNT_EN
   logic [5:0] cycle_cnt;
`endif

   modport master (
`ifdef BOOTH_CYCLE_CNT_EN
      output cycle_cnt,
`endif
      input  start, q0, qm1, eqz,
      output LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt,
      output busy, done
   );

   modport slave (
`ifdef BOOTH_CYCLE_CNT_EN
      input  cycle_cnt,
`endif
      output start, q0, qm1, eqz,
      input  LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt,
      input  busy, done
   );
endinterface

`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
//  Module      : booth_controller
//  Description : Moore FSM sequencing a 16-bit, 16-iteration radix-2 Booth
//                multiplier datapath.
//  Ports       : clk    - single clock, rising edge
//                reset  - asynchronous, active-low
//                bus    - booth_controller_if.master
//                         in : start, q0, qm1, eqz
//                         out: LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ,
//                              addsub, decr, ldcnt, busy, done,
//                              cycle_cnt (BOOTH_CYCLE_CNT_EN only)
//  Options     : BOOTH_CYCLE_CNT_EN - adds a 6-bit count of the cycles used
//                by the last operation (LOAD_M through DONE inclusive).
//  Revision    : 1.0  initial release
// ============================================================================
module booth_controller (
   input wire               clk,
   input wire               reset,
   booth_controller_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_M = 3'd1,
      S_LOAD_Q = 3'd2,
      S_CHECK  = 3'd3,
      S_ADDSUB = 3'd4,
      S_SHIFT  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t state_q;
   state_t state_d;

   // Operation chosen in CHECK, consumed in the following ADDSUB: 1 = add.
   logic   op_q;
   logic   op_d;

   logic   ld_a;
   logic   ld_q;
   logic   ld_m;
   logic   clr_a;
   logic   clr_ff;
   logic   sft_a;
   logic   sft_q;
   logic   add_sub;
   logic   decr_c;
   logic   ld_cnt;
   logic   busy_c;
   logic   done_c;

   // ------------------------------------------------------------------------
   // State and op registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and Moore output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ld_a    = 1'b0;
      ld_q    = 1'b0;
      ld_m    = 1'b0;
      clr_a   = 1'b0;
      clr_ff  = 1'b0;
      sft_a   = 1'b0;
      sft_q   = 1'b0;
      add_sub = 1'b0;
      decr_c  = 1'b0;
      ld_cnt  = 1'b0;
      busy_c  = 1'b1;
      done_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_c = 1'b0;
            if (bus.start) begin
               state_d = S_LOAD_M;
            end
         end

         S_LOAD_M: begin
            ld_m    = 1'b1;
            clr_a   = 1'b1;
            state_d = S_LOAD_Q;
         end

         S_LOAD_Q: begin
            ld_q    = 1'b1;
            ld_cnt  = 1'b1;
            clr_ff  = 1'b1;
            state_d = S_CHECK;
         end

         // The counter is tested before the Booth pair so that the 17th
         // visit (counter exhausted) terminates regardless of Q[0]/Q(-1).
         S_CHECK: begin
            if (bus.eqz) begin
               state_d = S_DONE;
            end else begin
               case ({bus.q0, bus.qm1})
                  2'b01: begin
                     op_d    = 1'b1;
                     state_d = S_ADDSUB;
                  end
                  2'b10: begin
                     op_d    = 1'b0;
                     state_d = S_ADDSUB;
                  end
                  default: begin
                     state_d = S_SHIFT;
                  end
               endcase
            end
         end

         S_ADDSUB: begin
            ld_a    = 1'b1;
            add_sub = op_q;
            state_d = S_SHIFT;
         end

         S_SHIFT: begin
            sft_a   = 1'b1;
            sft_q   = 1'b1;
            decr_c  = 1'b1;
            state_d = S_CHECK;
         end

         S_DONE: begin
            done_c  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            busy_c  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.LdA    = ld_a;
   assign bus.LdQ    = ld_q;
   assign bus.LdM    = ld_m;
   assign bus.clrA   = clr_a;
   // Q is always overwritten by LdQ, so it never needs clearing.
   assign bus.clrQ   = 1'b0;
   assign bus.clrff  = clr_ff;
   assign bus.sftA   = sft_a;
   assign bus.sftQ   = sft_q;
   assign bus.addsub = add_sub;
   assign bus.decr   = decr_c;
   assign bus.ldcnt  = ld_cnt;
   assign bus.busy   = busy_c;
   assign bus.done   = done_c;

`ifdef BOOTH_CYCLE_CNT_EN
   // ------------------------------------------------------------------------
   // Cycle counter: value equals the index of the current cycle within the
   // operation (LOAD_M = 1). It stops advancing in DONE so the final total
   // is held through IDLE until the next launch.
   // ------------------------------------------------------------------------
   logic [5:0] cycle_cnt_q;
   logic [5:0] cycle_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if ((state_q == S_IDLE) && (state_d == S_LOAD_M)) begin
         cycle_cnt_d = 6'd1;
      end else if ((state_q != S_IDLE) && (state_q != S_DONE)) begin
         cycle_cnt_d = cycle_cnt_q + 6'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt_q <= 6'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign bus.cycle_cnt = cycle_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_booth_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_controller
//  Description : Self-checking bench for booth_controller with a behavioural
//                Booth datapath attached; directed multiply vectors with
//                hand-computed products, ADDSUB counts and latencies.
//  Options     : BOOTH_CYCLE_CNT_EN - also checks cycle_cnt.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_controller;

   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   booth_controller_if bus ();

   booth_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------------------------
   // Behavioural datapath
   // ------------------------------------------------------------------------
   logic [15:0] op_m;
   logic [15:0] op_q;
   logic [15:0] dp_in;
   logic [15:0] dp_a;
   logic [15:0] dp_qr;
   logic [15:0] dp_m;
   logic        dp_qm1;
   logic [4:0]  dp_cnt;

   assign dp_in   = bus.LdM ? op_m : op_q;
   assign bus.q0  = dp_qr[0];
   assign bus.qm1 = dp_qm1;
   assign bus.eqz = (dp_cnt == 5'd0);

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         dp_a   <= 16'd0;
         dp_qr  <= 16'd0;
         dp_m   <= 16'd0;
         dp_qm1 <= 1'b0;
         dp_cnt <= 5'd0;
      end else begin
         if (bus.LdM)   dp_m   <= dp_in;
         if (bus.clrA)  dp_a   <= 16'd0;
         if (bus.LdQ)   dp_qr  <= dp_in;
         if (bus.clrff) dp_qm1 <= 1'b0;
         if (bus.ldcnt) dp_cnt <= 5'd16;
         if (bus.LdA)   dp_a   <= bus.addsub ? (dp_a + dp_m) : (dp_a - dp_m);
         if (bus.sftA) begin
            dp_a   <= {dp_a[15], dp_a[15:1]};
            dp_qr  <= {dp_a[0], dp_qr[15:1]};
            dp_qm1 <= dp_qr[0];
         end
         if (bus.decr)  dp_cnt <= dp_cnt - 5'd1;
      end
   end

   // Control vector: LdA LdQ LdM clrA clrQ clrff sftA sftQ addsub decr ldcnt
   logic [10:0] ctl;
   assign ctl = {bus.LdA, bus.LdQ, bus.LdM, bus.clrA, bus.clrQ, bus.clrff,
                 bus.sftA, bus.sftQ, bus.addsub, bus.decr, bus.ldcnt};

   int done_pulses = 0;
   int viol        = 0;

   always @(negedge clk) begin
      if (bus.done) done_pulses <= done_pulses + 1;
      if (bus.clrQ || (bus.addsub && !bus.LdA)) viol <= viol + 1;
   end

   // ------------------------------------------------------------------------
   // One multiply. Latency counts posedges from the one sampling start to
   // the one leaving DONE.
   // ------------------------------------------------------------------------
   task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                         input logic [31:0] exp_prod, input int exp_k,
                         input int exp_first_as, input bit inject, input bit hold);
      int n;
      int k;
      int first_as;
      int pulses0;
      bit injected;
      op_m    = m;
      op_q    = q;
      pulses0 = done_pulses;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      if (!hold) bus.start = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_ldm"}, 32'(ctl), 32'h180);
      @(posedge clk); #1;
      chk({tag, "_ldq"}, 32'(ctl), 32'h221);
      n        = 1;
      k        = 0;
      first_as = -1;
      injected = 1'b0;
      while (!bus.done && n < 120) begin
         @(posedge clk); #1;
         if (inject) bus.start = 1'b0;
         n++;
         if (bus.LdA) begin
            k++;
            if (first_as < 0) first_as = int'(bus.addsub);
         end
         if (inject && !injected && bus.sftA) begin
            bus.start = 1'b1;
            injected  = 1'b1;
         end
      end
      chk({tag, "_latency"}, 32'(n + 1), 32'(36 + exp_k));
      chk({tag, "_k"}, 32'(k), 32'(exp_k));
      chk({tag, "_prod"}, {dp_a, dp_qr}, exp_prod);
      if (exp_first_as >= 0) chk({tag, "_first_addsub"}, 32'(first_as), 32'(exp_first_as));
      @(posedge clk); #1;
      chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
`ifdef BOOTH_CYCLE_CNT_EN
      chk({tag, "_cycle_cnt"}, 32'(bus.cycle_cnt), 32'(36 + exp_k));
`endif
      if (hold) begin
         @(posedge clk); #1;
         chk({tag, "_relaunch_busy"}, 32'(bus.busy), 32'd1);
         chk({tag, "_relaunch_ldm"}, 32'(ctl), 32'h180);
         bus.start = 1'b0;
         n = 0;
         while (!bus.done && n < 120) begin
            @(posedge clk); #1;
            n++;
         end
         @(posedge clk); #1;
      end else begin
         repeat (45) @(posedge clk);
         #1;
         chk({tag, "_done_pulses"}, 32'(done_pulses - pulses0), 32'd1);
         chk({tag, "_quiet"}, 32'(bus.busy), 32'd0);
      end
   endtask

   // Reset asserted while the FSM sits in ADDSUB.
   task automatic run_abort();
      int n;
      int pulses0;
      op_m    = 16'd3;
      op_q    = 16'd5;
      pulses0 = done_pulses;
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (!bus.LdA && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_in_addsub", 32'(bus.LdA), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_ctl", 32'(ctl), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
`ifdef BOOTH_CYCLE_CNT_EN
      chk("abort_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
`endif
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done_pulses - pulses0), 32'd0);
      chk("abort_stays_idle", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      op_m      = 16'd0;
      op_q      = 16'd0;
      #1;
      reset = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_ctl", 32'(ctl), 32'd0);
`ifdef BOOTH_CYCLE_CNT_EN
      chk("rst_cycle_cnt", 32'(bus.cycle_cnt), 32'd0);
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_op("m3x5",    16'd3,      16'd5,      32'd15,         4,  -1, 1'b0, 1'b0);
      run_op("mul0",    16'h1234,   16'd0,      32'd0,          0,  -1, 1'b0, 1'b0);
      run_op("m2x5555", 16'd2,      16'h5555,   32'h0000_AAAA,  16, -1, 1'b0, 1'b0);
      run_op("n7x6",    16'hFFF9,   16'd6,      32'hFFFF_FFD6,  2,  0,  1'b0, 1'b0);
      run_op("midshift",16'd3,      16'd5,      32'd15,         4,  -1, 1'b1, 1'b0);
      run_op("hold",    16'd2,      16'd3,      32'd6,          2,  0,  1'b0, 1'b1);
      run_abort();
      run_op("post_rst",16'd3,      16'd5,      32'd15,         4,  0,  1'b0, 1'b0);

      chk("no_clrq_or_stray_addsub", 32'(viol), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/booth_controller.md
BOOTH_CONTROLLER -- requirements
Module: booth_controller

Interface
REQ-001 Parameters: none; the operand width is fixed at 16 bits and the iteration count at 16.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request for a multiply; sampled in IDLE only.
REQ-005 q0  input  1  datapath Q[0].
REQ-006 qm1  input  1  datapath Q(-1) flop output.
REQ-007 eqz  input  1  high when the datapath iteration counter is zero.
REQ-008 LdA, LdQ, LdM, clrA, clrQ, clrff, sftA, sftQ, addsub, decr, ldcnt  output  1 each  datapath controls.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 cycle_cnt  output  6  cycles used by the last operation; present only with BOOTH_CYCLE_CNT_EN.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD_M, LOAD_Q, CHECK, ADDSUB, SHIFT and DONE, held in a state register with Moore-decoded outputs.
REQ-013 IDLE: start=1 -> LOAD_M, else stay; all controls low.
REQ-014 LOAD_M: assert LdM and clrA; the host holds the multiplicand on data_in during this cycle; next state LOAD_Q.
REQ-015 LOAD_Q: assert LdQ, ldcnt and clrff; the host holds the multiplier on data_in; next state CHECK.
REQ-016 CHECK: assert no controls.
REQ-017 CHECK transitions: eqz=1 -> DONE; {q0,qm1}=01 -> ADDSUB with an internal op bit set to add; {q0,qm1}=10 -> ADDSUB with op=sub; 00 or 11 -> SHIFT.
REQ-018 ADDSUB: assert LdA, and drive addsub=1 for add or 0 for sub from the op bit registered in CHECK; next state SHIFT.
REQ-019 SHIFT: assert sftA, sftQ and decr together; next state CHECK.
REQ-020 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-021 addsub SHALL be 0 in every state except an add-type ADDSUB.
REQ-022 Latency from the edge that samples start to the edge that leaves DONE SHALL be 36+k cycles, where k is the number of ADDSUB visits (0..16).
REQ-023 A start asserted while busy=1 SHALL be ignored; no request is queued.
REQ-024 start held high through DONE SHALL launch a new operation only after one full cycle in IDLE.
REQ-025 clrQ SHALL never be asserted; Q is overwritten by LdQ.
REQ-026 eqz, q0 and qm1 SHALL be ignored in every state except CHECK.

Reset
REQ-027 Asserting reset low SHALL immediately force IDLE, the op bit to 0, and all outputs to 0, including cycle_cnt when present.
REQ-028 A reset during any state SHALL abandon the operation with no done pulse.
REQ-029 Operation SHALL resume from IDLE on the first clock edge after reset deasserts.

Configuration
REQ-030 With BOOTH_CYCLE_CNT_EN defined, a 6-bit cycle_cnt SHALL clear to 1 on entry to LOAD_M and increment once per cycle through DONE inclusive.
REQ-031 With BOOTH_CYCLE_CNT_EN defined, cycle_cnt SHALL hold its final value (36+k) in IDLE until the next start.
REQ-032 Without BOOTH_CYCLE_CNT_EN, the cycle_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Multiplicand 3, multiplier 5 with the datapath attached -> A:Q=15 at done; k=4, so done appears 40 cycles after start is sampled.
REQ-034 Multiplier 0 -> no ADDSUB visits; done after 36 cycles; A:Q=0.
REQ-035 Multiplier 16'h5555 -> k=16; done after 52 cycles; cycle_cnt=52 when BOOTH_CYCLE_CNT_EN is defined.
REQ-036 -7 x 6 -> A:Q=32'hFFFFFFD6; addsub=0 on the first ADDSUB visit.
REQ-037 start pulsed in mid-SHIFT -> ignored; exactly one done pulse.
REQ-038 reset driven low during ADDSUB -> busy=0 and all controls 0 without waiting for a clock; no done pulse; the next start completes normally.
